// File: rtl/td4_run_ctrl_if.sv
// Board-side bundle of the TD4 run controller: raw buttons, CPU fetch bus, CPU drive and status.
interface td4_run_ctrl_if;
    logic       btn_run;
    logic       btn_step;
    logic       btn_speed;
    logic [3:0] pc;
    logic [7:0] instr;
    logic       cpu_clk;
    logic       cpu_n_reset;
    logic [7:0] step_count;
    logic       running;
    logic       halted;
    logic       fast;
    logic [2:0] state;

    modport master (
        input  btn_run, btn_step, btn_speed, pc, instr,
        output cpu_clk, cpu_n_reset, step_count, running, halted, fast, state
    );

    modport slave (
        output btn_run, btn_step, btn_speed, pc, instr,
        input  cpu_clk, cpu_n_reset, step_count, running, halted, fast, state
    );
endinterface

// File: rtl/td4_run_ctrl.sv
// Run/step/halt sequencer for the TD4 CPU: debounced buttons, rate divider,
// fixed-width cpu_clk pulses and self-jump halt detection.
module td4_run_btn #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // New level accepted; only a 0->1 acceptance is a press.
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module td4_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SLOW_DIV        = 25000000,
    parameter int FAST_DIV        = 2500000,
    parameter int PULSE_W         = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input logic            clk,
    input logic            reset,
    td4_run_ctrl_if.master bus
);
    localparam int NUM_BTN = 3;
    localparam int DW      = $clog2(SLOW_DIV) + 1;
    localparam int PW      = $clog2(PULSE_W) + 1;
    localparam int HW      = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        PAUSED   = 3'd1,
        RUNNING  = 3'd2,
        STEPPING = 3'd3,
        HALTED   = 3'd4
    } state_t;

    state_t             st;
    logic [NUM_BTN-1:0] raw, press;
    logic               run_p, step_p, speed_p;
    logic [DW-1:0]      div, period_m1;
    logic [PW-1:0]      pcnt;
    logic [HW-1:0]      hcnt;
    logic [7:0]         steps;
    logic               cpu_clk, n_rst, running, halted, fast;
    logic               tick, self_jump;

    assign raw = {bus.btn_speed, bus.btn_step, bus.btn_run};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        td4_run_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .press(press[i])
        );
    end

    assign run_p     = press[0];
    assign step_p    = press[1];
    assign speed_p   = press[2];
    assign period_m1 = fast ? DW'(FAST_DIV - 1) : DW'(SLOW_DIV - 1);
    // A speed press restarts the divider, so it swallows a coinciding tick.
    assign tick      = (st == RUNNING) && (div == period_m1) && !speed_p;
    assign self_jump = (bus.instr == {4'b1111, bus.pc});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= HOLD;
            cpu_clk <= 1'b0;
            n_rst   <= 1'b0;
            steps   <= '0;
            running <= 1'b0;
            halted  <= 1'b0;
            fast    <= 1'b0;
            div     <= '0;
            pcnt    <= '0;
            hcnt    <= '0;
        end else begin
            // An in-flight pulse always runs to its full width.
            if (cpu_clk) begin
                if (pcnt == PW'(PULSE_W - 1)) cpu_clk <= 1'b0;
                else                          pcnt    <= pcnt + PW'(1);
            end

            if (speed_p && st != HOLD) fast <= ~fast;

            if (st == RUNNING && !speed_p) div <= (div == period_m1) ? '0 : div + DW'(1);
            else                           div <= '0;

            case (st)
                HOLD: begin
                    if (hcnt == HW'(HOLD_CYCLES - 1)) begin
                        st    <= PAUSED;
                        n_rst <= 1'b1;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                PAUSED: begin
                    if (run_p) begin
                        st      <= RUNNING;
                        running <= 1'b1;
                    end else if (step_p && !cpu_clk) begin
                        st      <= STEPPING;
                        cpu_clk <= 1'b1;
                        pcnt    <= '0;
                        steps   <= steps + 8'd1;
                    end
                end
                RUNNING: begin
                    if (run_p) begin
                        st      <= PAUSED;
                        running <= 1'b0;
                    end else if (tick) begin
                        if (self_jump) begin
                            st      <= HALTED;
                            running <= 1'b0;
                            halted  <= 1'b1;
                        end else begin
                            cpu_clk <= 1'b1;
                            pcnt    <= '0;
                            steps   <= steps + 8'd1;
                        end
                    end
                end
                STEPPING: begin
                    if (cpu_clk && pcnt == PW'(PULSE_W - 1)) st <= PAUSED;
                end
                HALTED: begin
                    if (run_p) begin
                        st     <= PAUSED;
                        halted <= 1'b0;
                    end
                end
                default: st <= HOLD;
            endcase
        end
    end

    assign bus.cpu_clk     = cpu_clk;
    assign bus.cpu_n_reset = n_rst;
    assign bus.step_count  = steps;
    assign bus.running     = running;
    assign bus.halted      = halted;
    assign bus.fast        = fast;
    assign bus.state       = st;
endmodule
